// File: rtl/bookkeeping_directory_pkg.sv
// Shared defaults, derived widths, FSM encoding and slot geometry
// for the parametrised bookkeeping directory.
package bookkeeping_directory_pkg;

  localparam int DEF_INDEX_WIDTH     = 12;
  localparam int DEF_TAG_WIDTH       = 18;
  localparam int DEF_STATE_WIDTH     = 2;
  localparam int DEF_NUM_CORES       = 2;
  localparam int DEF_NUM_CACHE_TYPES = 2;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_ROW      = DEF_STATE_WIDTH + DEF_TAG_WIDTH;
  localparam int DEF_CW       = clog2_min1(DEF_NUM_CORES);
  localparam int DEF_TW       = clog2_min1(DEF_NUM_CACHE_TYPES);
  localparam int DEF_SLOTS    = DEF_NUM_CORES * DEF_NUM_CACHE_TYPES;
  localparam int DEF_ENTRY    = DEF_SLOTS * DEF_ROW;
  localparam int DEF_REQ      = DEF_INDEX_WIDTH + 1 + DEF_ROW + DEF_CW + DEF_TW;
  localparam int DEF_NUM_SETS = 1 << DEF_INDEX_WIDTH;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dir_state_e;

  // MSB position of a slot's row; slot 0 occupies the top of the entry.
  function automatic int slot_offset(input int slot, input int row_w, input int entry_w);
    return entry_w - 1 - slot * row_w;
  endfunction

endpackage

// File: rtl/dir_entry_merge.sv
// Replaces one (core, cache type) row of a directory entry; used by both
// the write-back path and the write-to-lookup forwarding path.
module dir_entry_merge
  import bookkeeping_directory_pkg::*;
#(
  parameter  int ROW             = DEF_ROW,
  parameter  int NUM_CORES       = DEF_NUM_CORES,
  parameter  int NUM_CACHE_TYPES = DEF_NUM_CACHE_TYPES,
  localparam int CW              = clog2_min1(NUM_CORES),
  localparam int TW              = clog2_min1(NUM_CACHE_TYPES),
  localparam int ENTRY           = NUM_CORES * NUM_CACHE_TYPES * ROW
) (
  input  logic [ENTRY-1:0] base,
  input  logic [ROW-1:0]   row,
  input  logic [CW-1:0]    core_id,
  input  logic [TW-1:0]    cache_type,
  output logic [ENTRY-1:0] merged
);

  // Only in-range pairs are enumerated, so an out-of-range slot leaves base untouched.
  always_comb begin
    merged = base;
    for (int c = 0; c < NUM_CORES; c++) begin
      for (int t = 0; t < NUM_CACHE_TYPES; t++) begin
        merged[slot_offset(c * NUM_CACHE_TYPES + t, ROW, ENTRY) -: ROW] =
          ((int'(core_id) == c) && (int'(cache_type) == t)) ?
          row : base[slot_offset(c * NUM_CACHE_TYPES + t, ROW, ENTRY) -: ROW];
      end
    end
  end

endmodule

// File: rtl/bookkeeping_directory_param.sv
// Bookkeeping directory: one MSI state+tag row per (core, cache type) per set,
// served through put/get handshakes over a synchronous-read array.
module bookkeeping_directory_param
  import bookkeeping_directory_pkg::*;
#(
  parameter  int INDEX_WIDTH     = DEF_INDEX_WIDTH,
  parameter  int TAG_WIDTH       = DEF_TAG_WIDTH,
  parameter  int STATE_WIDTH     = DEF_STATE_WIDTH,
  parameter  int NUM_CORES       = DEF_NUM_CORES,
  parameter  int NUM_CACHE_TYPES = DEF_NUM_CACHE_TYPES,
  localparam int ROW      = STATE_WIDTH + TAG_WIDTH,
  localparam int CW       = clog2_min1(NUM_CORES),
  localparam int TW       = clog2_min1(NUM_CACHE_TYPES),
  localparam int SLOTS    = NUM_CORES * NUM_CACHE_TYPES,
  localparam int ENTRY    = SLOTS * ROW,
  localparam int REQ      = INDEX_WIDTH + 1 + ROW + CW + TW,
  localparam int NUM_SETS = 1 << INDEX_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             put_valid,
  output logic             put_ready,
  input  logic [REQ-1:0]   put_request,
  input  logic             get_valid,
  output logic             get_ready,
  output logic [ENTRY-1:0] get_response,
  output logic             init_done
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = {INDEX_WIDTH{1'b1}};

  dir_state_e             state_q, state_d;
  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
  logic                   init_done_q, init_done_d;
  logic                   s1_valid_q, s1_valid_d, s1_write_q, s1_write_d;
  logic [INDEX_WIDTH-1:0] s1_idx_q, s1_idx_d;
  logic [ROW-1:0]         s1_row_q, s1_row_d;
  logic [CW-1:0]          s1_core_q, s1_core_d;
  logic [TW-1:0]          s1_type_q, s1_type_d;
  logic                   fwd_hit_q, fwd_hit_d;
  logic [ENTRY-1:0]       fwd_data_q, fwd_data_d;
  logic                   get_ready_q, get_ready_d;
  logic [ENTRY-1:0]       rd_data_q;
  logic [ENTRY-1:0]       mem [NUM_SETS];

  logic                   fire_s, req_write_s, mem_we_s;
  logic [INDEX_WIDTH-1:0] req_idx_s, mem_waddr_s;
  logic [ROW-1:0]         req_row_s;
  logic [CW-1:0]          req_core_s;
  logic [TW-1:0]          req_type_s;
  logic [ENTRY-1:0]       base_s, merged_s, mem_wdata_s;

  assign req_idx_s   = put_request[REQ-1 -: INDEX_WIDTH];
  assign req_write_s = put_request[CW + TW + ROW];
  assign req_row_s   = put_request[CW + TW +: ROW];
  assign req_core_s  = put_request[TW +: CW];
  assign req_type_s  = put_request[0 +: TW];

  assign fire_s       = put_valid && put_ready;
  assign base_s       = fwd_hit_q ? fwd_data_q : rd_data_q;
  assign get_ready    = get_ready_q;
  assign get_response = get_ready_q ? base_s : {ENTRY{1'b0}};
  assign init_done    = init_done_q;

  dir_entry_merge #(
    .ROW             (ROW),
    .NUM_CORES       (NUM_CORES),
    .NUM_CACHE_TYPES (NUM_CACHE_TYPES)
  ) u_merge (
    .base       (base_s),
    .row        (s1_row_q),
    .core_id    (s1_core_q),
    .cache_type (s1_type_q),
    .merged     (merged_s)
  );

  // FSM state register and pipeline/response registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= INIT;
      cnt_q       <= {INDEX_WIDTH{1'b0}};
      init_done_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_write_q  <= 1'b0;
      s1_idx_q    <= {INDEX_WIDTH{1'b0}};
      s1_row_q    <= {ROW{1'b0}};
      s1_core_q   <= {CW{1'b0}};
      s1_type_q   <= {TW{1'b0}};
      fwd_hit_q   <= 1'b0;
      fwd_data_q  <= {ENTRY{1'b0}};
      get_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      s1_valid_q  <= s1_valid_d;
      s1_write_q  <= s1_write_d;
      s1_idx_q    <= s1_idx_d;
      s1_row_q    <= s1_row_d;
      s1_core_q   <= s1_core_d;
      s1_type_q   <= s1_type_d;
      fwd_hit_q   <= fwd_hit_d;
      fwd_data_q  <= fwd_data_d;
      get_ready_q <= get_ready_d;
    end
  end

  // Next state: the clear sweep walks every set once, then the directory runs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + INDEX_WIDTH'(1);
        if (cnt_q == LAST_IDX) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end else begin
          state_d     = INIT;
          init_done_d = 1'b0;
        end
      end
      RUN: begin
        state_d     = RUN;
        init_done_d = 1'b1;
      end
      default: begin
        state_d     = INIT;
        init_done_d = 1'b0;
      end
    endcase
  end

  // Outputs: handshake readiness and the single array write port.
  always_comb begin
    put_ready   = 1'b0;
    mem_we_s    = 1'b0;
    mem_waddr_s = cnt_q;
    mem_wdata_s = {ENTRY{1'b0}};
    case (state_q)
      INIT: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = cnt_q;
        mem_wdata_s = {ENTRY{1'b0}};
      end
      RUN: begin
        put_ready   = !get_ready_q || get_valid;
        mem_we_s    = s1_valid_q && s1_write_q;
        mem_waddr_s = s1_idx_q;
        mem_wdata_s = merged_s;
      end
      default: begin
        put_ready = 1'b0;
        mem_we_s  = 1'b0;
      end
    endcase
  end

  // Stage-1 capture; a write committing while the same set is read is forwarded,
  // because the array returns the pre-write contents in that cycle.
  always_comb begin
    s1_valid_d = fire_s;
    if (fire_s) begin
      s1_write_d = req_write_s;
      s1_idx_d   = req_idx_s;
      s1_row_d   = req_row_s;
      s1_core_d  = req_core_s;
      s1_type_d  = req_type_s;
      fwd_hit_d  = s1_valid_q && s1_write_q && (s1_idx_q == req_idx_s);
      fwd_data_d = merged_s;
    end else begin
      s1_write_d = s1_write_q;
      s1_idx_d   = s1_idx_q;
      s1_row_d   = s1_row_q;
      s1_core_d  = s1_core_q;
      s1_type_d  = s1_type_q;
      fwd_hit_d  = fwd_hit_q;
      fwd_data_d = fwd_data_q;
    end
    if (fire_s && !req_write_s) begin
      get_ready_d = 1'b1;
    end else if (get_valid && get_ready_q) begin
      get_ready_d = 1'b0;
    end else begin
      get_ready_d = get_ready_q;
    end
  end

  // Synchronous-read storage; read data only advances on an accepted request
  // so a pending response stays stable under backpressure.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
    if (fire_s) begin
      rd_data_q <= mem[req_idx_s];
    end
  end

`ifdef SIMULATION
  // Request trace for simulation builds.
  always_ff @(posedge CLK) begin
    if (fire_s) begin
      $display("%s idx=%0h core=%0d cache=%0d row=%0h", req_write_s ? "SET" : "GET",
               req_idx_s, req_core_s, req_type_s, req_row_s);
    end
  end
`endif

endmodule
